offset_button_conditioner: RTL

//   Turns four raw, bouncy push-buttons {Right, Left, Down, Up} into clean, glitch-free move pulses.

---
 rtl/offset_button_conditioner_pkg.sv | 19 +
 rtl/offset_button_conditioner_btn_channel.sv | 127 ++++++++++++
 rtl/offset_button_conditioner.sv | 49 ++++
 3 files changed

// File: rtl/offset_button_conditioner_pkg.sv
// Shared constants for the button conditioner: direction bit indices and
// channel FSM state encodings.
package offset_button_conditioner_pkg;

  localparam int unsigned NUM_BTN = 4;

  localparam int unsigned UP    = 0;
  localparam int unsigned DOWN  = 1;
  localparam int unsigned LEFT  = 2;
  localparam int unsigned RIGHT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRE  = 2'd1,
    DELAY = 2'd2,
    RATE  = 2'd3
  } btn_state_t;

endpackage

// File: rtl/offset_button_conditioner_btn_channel.sv
// One button: 2-flop synchroniser, debouncer, and pulse/auto-repeat FSM with
// registered clean level and flag outputs.
module offset_button_conditioner_btn_channel
  import offset_button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter int unsigned PULSE_WIDTH     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  input  logic i_enable,
  input  logic i_inhibit,
  output logic o_clean,
  output logic o_flag
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TM_W  = $clog2(T_MAX + 1);
  localparam int unsigned PW_W  = $clog2(PULSE_WIDTH + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] RATE_LAST  = TM_W'(REPEAT_PERIOD - 1);
  localparam logic [PW_W-1:0] PW_LAST    = PW_W'(PULSE_WIDTH - 1);

  logic [1:0]      r_sync;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_clean;

  btn_state_t      r_state, w_state_nxt;
  logic [TM_W-1:0] r_tmr, w_tmr_nxt;
  logic [PW_W-1:0] r_pcnt, w_pcnt_nxt;
  logic            r_first, w_first_nxt;
  logic            r_flag;

  logic [TM_W-1:0] w_tmr_last;
  logic            w_tmr_done;
  logic            w_can_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_raw};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_cnt <= '0;
      r_clean  <= 1'b0;
    end else if (r_sync[1] == r_clean) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db_cnt <= '0;
      r_clean  <= r_sync[1];
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // r_first marks that the current wait follows the initial press pulse
  assign w_tmr_last = r_first ? DELAY_LAST : RATE_LAST;
  assign w_tmr_done = (r_tmr == w_tmr_last);
  assign w_can_fire = i_enable && !i_inhibit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_tmr   <= '0;
      r_pcnt  <= '0;
      r_first <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_first <= w_first_nxt;
      r_flag  <= (w_state_nxt == FIRE);
    end
  end

  // Timer counts enabled cycles since FIRE entry and parks at its limit
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_pcnt_nxt  = r_pcnt;
    w_first_nxt = r_first;
    if ((r_state != IDLE) && i_enable && !w_tmr_done) w_tmr_nxt = r_tmr + TM_W'(1);
    case (r_state)
      IDLE: begin
        if (r_clean && w_can_fire) begin
          w_state_nxt = FIRE;
          w_tmr_nxt   = '0;
          w_pcnt_nxt  = '0;
          w_first_nxt = 1'b1;
        end
      end
      FIRE: begin
        if (r_pcnt == PW_LAST) begin
          if (!r_clean)     w_state_nxt = IDLE;
          else if (r_first) w_state_nxt = DELAY;
          else              w_state_nxt = RATE;
        end else begin
          w_pcnt_nxt = r_pcnt + PW_W'(1);
        end
      end
      DELAY, RATE: begin
        if (!r_clean) begin
          w_state_nxt = IDLE;
        end else if (w_tmr_done && w_can_fire) begin
          w_state_nxt = FIRE;
          w_tmr_nxt   = '0;
          w_pcnt_nxt  = '0;
          w_first_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_clean = r_clean;
  assign o_flag  = r_flag;

endmodule

// File: rtl/offset_button_conditioner.sv
// Four-button conditioner: per-button channels plus opposite-pair inhibit;
// outputs come straight from channel registers.
module offset_button_conditioner
  import offset_button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter int unsigned PULSE_WIDTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btnRaw,
  input  logic       enable,
  output logic [3:0] offsetFlag,
  output logic [3:0] btnClean
);

  logic [NUM_BTN-1:0] w_clean;
  logic [NUM_BTN-1:0] w_flag;
  logic [NUM_BTN-1:0] w_inhibit;

  // A channel may not fire while its opposite button is also held
  assign w_inhibit[UP]    = w_clean[DOWN];
  assign w_inhibit[DOWN]  = w_clean[UP];
  assign w_inhibit[LEFT]  = w_clean[RIGHT];
  assign w_inhibit[RIGHT] = w_clean[LEFT];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    offset_button_conditioner_btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .PULSE_WIDTH    (PULSE_WIDTH)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (btnRaw[g]),
      .i_enable (enable),
      .i_inhibit(w_inhibit[g]),
      .o_clean  (w_clean[g]),
      .o_flag   (w_flag[g])
    );
  end

  assign offsetFlag = w_flag;
  assign btnClean   = w_clean;

endmodule
